// File: rtl/etm_pkg.sv
// rtl/etm_pkg.sv - shared constants and helpers for the ETM approximate-region pipeline
package etm_pkg;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_ZERO = 1'b1;

  // Bits needed to hold a leading-zero count in 0..w inclusive.
  function automatic int lz_width(input int w);
    int n;
    n = 0;
    while ((1 << n) < (w + 1)) n++;
    return n;
  endfunction

endpackage

// File: rtl/etm_approx_pipe_if.sv
// rtl/etm_approx_pipe_if.sv - operand/result stream bundle for etm_approx_pipe
interface etm_approx_pipe_if
  import etm_pkg::*;
#(
  parameter int W   = 8,
  parameter int LZW = lz_width(W)
);

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] c;
  logic [LZW-1:0] lz;

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, c, lz
  );

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, c, lz
  );

endinterface

// File: rtl/etm_mask_gen.sv
// rtl/etm_mask_gen.sv - combinational leading-one thermometer mask and leading-zero count
module etm_mask_gen
  import etm_pkg::*;
#(
  parameter  int W   = 8,
  localparam int LZW = lz_width(W)
) (
  input  logic [W-1:0]   o,
  input  logic           mode,
  output logic [2*W-1:0] c,
  output logic [LZW-1:0] lz
);

  logic [W-1:0] upper;
  logic         acc;
  int           cnt;
  logic         found;

  // Sweep from the MSB down: once a one is seen every lower upper-half bit is set.
  always_comb begin
    upper = '0;
    acc   = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      acc      = acc | o[i];
      upper[i] = acc;
    end
  end

  always_comb begin
    cnt   = W;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && o[i]) begin
        cnt   = W - 1 - i;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    c[2*W-1:W] = upper;
    c[W-1:0]   = (mode == MODE_ZERO) ? '0 : {W{upper[0]}};
    lz         = LZW'(cnt);
  end

endmodule

// File: rtl/etm_approx_pipe.sv
// rtl/etm_approx_pipe.sv - two-stage valid/ready pipeline around etm_mask_gen
module etm_approx_pipe
  import etm_pkg::*;
#(
  parameter  int W   = 8,
  localparam int LZW = lz_width(W)
) (
  input  logic               clk,
  input  logic               rst_n,
  etm_approx_pipe_if.slave   bus
);

  logic           s1_valid;
  logic [W-1:0]   s1_o;
  logic           s1_mode;
  logic           s2_valid;
  logic [2*W-1:0] s2_c;
  logic [LZW-1:0] s2_lz;
  logic           s1_adv;
  logic           s2_adv;
  logic [2*W-1:0] mg_c;
  logic [LZW-1:0] mg_lz;

  // S1 may fill even while S2 is stalled, so two beats can be held under backpressure.
  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_o     <= '0;
      s1_mode  <= MODE_FILL;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_o    <= bus.a | bus.b;
        s1_mode <= bus.mode;
      end
    end
  end

  etm_mask_gen #(.W(W)) u_mask_gen (
    .o    (s1_o),
    .mode (s1_mode),
    .c    (mg_c),
    .lz   (mg_lz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_c     <= '0;
      s2_lz    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_c  <= mg_c;
        s2_lz <= mg_lz;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.c         = s2_c;
  assign bus.lz        = s2_lz;

endmodule
